// File: rtl/tw_stream_harness.sv
// Stimulus driver and response checker for streaming ternary-weight classifiers.
// Streams IQ frames from a stimulus ROM into a DUT and checks every output vector against an expected ROM.
module tw_stream_harness #(
   parameter int BW_IN        = 16,
   parameter int IQ_PER_CYC   = 2,
   parameter int SIG_LEN_IN   = 1024,
   parameter int CH_OUT       = 24,
   parameter int BW_OUT       = 16,
   parameter int SIG_LEN_OUT  = 1,
   parameter int N_FRAMES     = 2,
   parameter int STALL_PERIOD = 0,
   parameter int TIMEOUT      = 65535,
   localparam int AW          = (SIG_LEN_IN > 1) ? $clog2(SIG_LEN_IN) : 1,
   localparam int EAW         = $clog2(SIG_LEN_OUT) + 1,
   localparam int DIW         = 2 * IQ_PER_CYC * BW_IN,
   localparam int DOW         = CH_OUT * BW_OUT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic [AW-1:0]  stim_addr,
   input  logic [DIW-1:0] stim_data,
   output logic [EAW-1:0] exp_addr,
   input  logic [DOW-1:0] exp_data,
   output logic           vld_in,
   output logic [DIW-1:0] data_in,
   input  logic           vld_out,
   input  logic [DOW-1:0] data_out,
   output logic           busy,
   output logic           done,
   output logic           pass,
   output logic           timeout,
   output logic [15:0]    err_cnt,
   output logic [15:0]    first_err_idx,
   output logic [1:0]     dbg_state
);

   // Streams carry no backpressure: vld_in marks a beat the DUT must take that cycle,
   // and every vld_out cycle in RUN is one output vector consumed by the checker.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam bit             STALL_EN   = (STALL_PERIOD > 1);
   localparam int             SW         = STALL_EN ? $clog2(STALL_PERIOD) : 1;
   localparam logic [SW-1:0]  STALL_LAST = STALL_EN ? SW'(STALL_PERIOD - 1) : '0;
   localparam logic [AW-1:0]  IQ_STEP    = AW'(IQ_PER_CYC);
   localparam logic [AW-1:0]  LAST_BEAT  = AW'(SIG_LEN_IN - IQ_PER_CYC);
   localparam logic [31:0]    TOTAL_LAST = 32'(N_FRAMES * SIG_LEN_OUT - 1);
   localparam logic [31:0]    TIMEOUT_W  = 32'(TIMEOUT);
   localparam logic [31:0]    OUT_MOD    = 32'(SIG_LEN_OUT);

   state_t         state_q;
   state_t         state_d;
   logic [AW-1:0]  in_idx_q;
   logic [SW-1:0]  cyc_q;
   logic [31:0]    out_idx_q;
   logic [31:0]    idle_q;
   logic [15:0]    err_q;
   logic [15:0]    first_q;
   logic           timeout_q;
   logic           pass_q;
   logic [DIW-1:0] hold_q;

   logic           in_run;
   logic           stall;
   logic           beat;
   logic [AW-1:0]  in_idx_nxt;
   logic           chk;
   logic           mism;
   logic [15:0]    err_nxt;
   logic           last_out;
   logic           tmo_hit;
   logic           start_ok;
   logic [31:0]    exp_idx;

   always_comb begin
      in_run     = (state_q == S_RUN);
      stall      = STALL_EN && (cyc_q == STALL_LAST);
      beat       = in_run && !stall;
      in_idx_nxt = (in_idx_q == LAST_BEAT) ? '0 : in_idx_q + IQ_STEP;
      chk        = in_run && vld_out;
      mism       = chk && (data_out != exp_data);
      err_nxt    = (mism && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
      last_out   = chk && (out_idx_q == TOTAL_LAST);
      // A vld_out cycle restarts the idle count, so completion always wins over timeout.
      tmo_hit    = in_run && !vld_out && (idle_q >= TIMEOUT_W);
      start_ok   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_ok) state_d = S_PRIME;
         S_PRIME: state_d = S_RUN;
         S_RUN:   if (last_out || tmo_hit) state_d = S_DONE;
         S_DONE:  if (start_ok) state_d = S_PRIME;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Address one beat ahead so the registered ROM read lands on the beat cycle;
   // the checker looks one vector ahead whenever the current vector is consumed.
   always_comb begin
      stim_addr     = beat ? in_idx_nxt : in_idx_q;
      exp_idx       = chk ? out_idx_q + 32'd1 : out_idx_q;
      exp_addr      = EAW'(exp_idx % OUT_MOD);
      vld_in        = beat;
      data_in       = beat ? stim_data : hold_q;
      busy          = (state_q == S_PRIME) || (state_q == S_RUN);
      done          = (state_q == S_DONE);
      pass          = pass_q;
      timeout       = timeout_q;
      err_cnt       = err_q;
      first_err_idx = first_q;
      dbg_state     = state_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_idx_q  <= '0;
         cyc_q     <= '0;
         out_idx_q <= '0;
         idle_q    <= '0;
         err_q     <= '0;
         first_q   <= 16'hFFFF;
         timeout_q <= 1'b0;
         pass_q    <= 1'b0;
         hold_q    <= '0;
      end else begin
         if (start_ok) begin
            in_idx_q  <= '0;
            cyc_q     <= '0;
            out_idx_q <= '0;
            idle_q    <= '0;
            err_q     <= '0;
            first_q   <= 16'hFFFF;
            timeout_q <= 1'b0;
            pass_q    <= 1'b0;
         end
         if (beat) begin
            hold_q   <= stim_data;
            in_idx_q <= in_idx_nxt;
         end
         if (in_run) begin
            cyc_q  <= (stall || !STALL_EN) ? '0 : cyc_q + SW'(1);
            idle_q <= vld_out ? 32'd0 : idle_q + 32'd1;
         end
         if (chk) begin
            out_idx_q <= out_idx_q + 32'd1;
            err_q     <= err_nxt;
            if (mism && (first_q == 16'hFFFF)) first_q <= out_idx_q[15:0];
         end
         if (in_run && (state_d == S_DONE)) begin
            timeout_q <= tmo_hit;
            pass_q    <= (err_nxt == 16'd0) && !tmo_hit;
         end
      end
   end

endmodule
